// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, constants and the ID/EX register layout for the
// LEGv8 operand stage.
//   DW       datapath width (64)
//   AW       register address width (5)
//   ZERO_REG architectural zero register (all ones)
//   idex_t   contents of the ID/EX pipeline register
package pipe_pkg;

  localparam int DW = 64;
  localparam int AW = 5;

  localparam logic [AW-1:0] ZERO_REG = 5'd31;

  typedef struct packed {
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;
    logic          regwrite;
    logic          memread;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [DW-1:0] imm;
  } idex_t;

endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: selects the operand value presented to the ALU for one source.
//   rs           source register address held in ID/EX
//   regVal       operand value captured into ID/EX
//   memRd/memRegwrite/memResult  EX/MEM forwarding source (highest priority)
//   wbRd/wbRegwrite/wbResult     MEM/WB forwarding source
//   fwdVal       forwarded operand
// The zero register always reads 0, even if an older instruction targets it.
module fwd_mux #(
  parameter int DW = pipe_pkg::DW,
  parameter int AW = pipe_pkg::AW
) (
  input  logic [AW-1:0] rs,
  input  logic [DW-1:0] regVal,
  input  logic [AW-1:0] memRd,
  input  logic          memRegwrite,
  input  logic [DW-1:0] memResult,
  input  logic [AW-1:0] wbRd,
  input  logic          wbRegwrite,
  input  logic [DW-1:0] wbResult,
  output logic [DW-1:0] fwdVal
);

  always_comb begin
    // NOTE: default assigned first so every path drives fwdVal; no latch.
    fwdVal = regVal;
    if (&rs) begin
      fwdVal = '0;
    end else if (memRegwrite && memRd == rs) begin
      fwdVal = memResult;
    end else if (wbRegwrite && wbRd == rs) begin
      fwdVal = wbResult;
    end
  end

endmodule

// File: rtl/operand_stage.sv
// operand_stage: ID/EX operand stage of the LEGv8 pipeline.
//   Captures regfile read data and decoded fields into ID/EX, bypasses a
//   same-edge regfile write at capture, forwards EX/MEM and MEM/WB results
//   onto the ALU operands, and inserts a one-cycle bubble on load-use.
// Ports:
//   clk, reset (async, active high), flush (kills the held instruction)
//   id_valid/id_ready         upstream handshake
//   id_rs1/rs2/use_rs1/use_rs2/rd/regwrite/memread/imm  decoded ID fields
//   rf_rdata1/rf_rdata2       register file read data
//   mem_rd/regwrite/result    EX/MEM forwarding source
//   wb_rd/regwrite/result     MEM/WB forwarding source (also the regfile write)
//   ex_valid/ex_ready         downstream handshake
//   ex_op_a/ex_op_b           forwarded operands
//   ex_imm/ex_rd/ex_regwrite/ex_memread  registered fields
// Build option OPERAND_STAGE_PERF_EN adds saturating 32-bit counters
//   perf_bubbles (load-use bubbles) and perf_stalls (id_valid && !id_ready).
// DW/AW must match pipe_pkg, which fixes the ID/EX register layout.
module operand_stage #(
  parameter int DW = pipe_pkg::DW,
  parameter int AW = pipe_pkg::AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          id_valid,
  output logic          id_ready,
  input  logic [AW-1:0] id_rs1,
  input  logic [AW-1:0] id_rs2,
  input  logic          id_use_rs1,
  input  logic          id_use_rs2,
  input  logic [AW-1:0] id_rd,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic [DW-1:0] id_imm,
  input  logic [DW-1:0] rf_rdata1,
  input  logic [DW-1:0] rf_rdata2,
  input  logic [AW-1:0] mem_rd,
  input  logic          mem_regwrite,
  input  logic [DW-1:0] mem_result,
  input  logic [AW-1:0] wb_rd,
  input  logic          wb_regwrite,
  input  logic [DW-1:0] wb_result,
  output logic          ex_valid,
  input  logic          ex_ready,
  output logic [DW-1:0] ex_op_a,
  output logic [DW-1:0] ex_op_b,
  output logic [DW-1:0] ex_imm,
  output logic [AW-1:0] ex_rd,
  output logic          ex_regwrite,
  output logic          ex_memread
`ifdef OPERAND_STAGE_PERF_EN
  ,
  output logic [31:0]   perf_bubbles,
  output logic [31:0]   perf_stalls
`endif
);

  import pipe_pkg::*;

  idex_t idex;
  idex_t capture;
  logic  exValid;
  logic  advance;
  logic  hazard;
  logic  accept;
  logic  wbHitRs1;
  logic  wbHitRs2;

  assign advance = !exValid || ex_ready;

  // A load in ID/EX whose result is needed by the instruction in ID cannot be
  // forwarded in time; the zero register never creates a dependency.
  assign hazard = exValid && idex.memread && (idex.rd != ZERO_REG) &&
                  ((id_use_rs1 && id_rs1 == idex.rd) ||
                   (id_use_rs2 && id_rs2 == idex.rd));

  assign id_ready = advance && !hazard && !flush;
  assign accept   = id_valid && id_ready;

  // The regfile write lands on the same edge as this capture, so its read
  // data is stale; take the write data directly.
  assign wbHitRs1 = wb_regwrite && (wb_rd == id_rs1) && (wb_rd != ZERO_REG);
  assign wbHitRs2 = wb_regwrite && (wb_rd == id_rs2) && (wb_rd != ZERO_REG);

  always_comb begin
    capture.rs1      = id_rs1;
    capture.rs2      = id_rs2;
    capture.rd       = id_rd;
    capture.regwrite = id_regwrite;
    capture.memread  = id_memread;
    capture.op_a     = wbHitRs1 ? wb_result : rf_rdata1;
    capture.op_b     = wbHitRs2 ? wb_result : rf_rdata2;
    capture.imm      = id_imm;
  end

  // NOTE: sequential state uses non-blocking assignments, and the async reset
  // clears every ID/EX field, not just the valid bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exValid <= 1'b0;
      idex    <= '0;
    end else if (flush) begin
      exValid <= 1'b0;
    end else if (advance && hazard) begin
      // Bubble: the dead slot must not look like a load or a register write.
      exValid       <= 1'b0;
      idex.regwrite <= 1'b0;
      idex.memread  <= 1'b0;
    end else if (accept) begin
      exValid <= 1'b1;
      idex    <= capture;
    end else if (advance) begin
      exValid <= 1'b0;
    end
  end

  assign ex_valid    = exValid;
  assign ex_imm      = idex.imm;
  assign ex_rd       = idex.rd;
  assign ex_regwrite = idex.regwrite;
  assign ex_memread  = idex.memread;

  fwd_mux #(.DW(DW), .AW(AW)) fwdA (
    .rs          (idex.rs1),
    .regVal      (idex.op_a),
    .memRd       (mem_rd),
    .memRegwrite (mem_regwrite),
    .memResult   (mem_result),
    .wbRd        (wb_rd),
    .wbRegwrite  (wb_regwrite),
    .wbResult    (wb_result),
    .fwdVal      (ex_op_a)
  );

  fwd_mux #(.DW(DW), .AW(AW)) fwdB (
    .rs          (idex.rs2),
    .regVal      (idex.op_b),
    .memRd       (mem_rd),
    .memRegwrite (mem_regwrite),
    .memResult   (mem_result),
    .wbRd        (wb_rd),
    .wbRegwrite  (wb_regwrite),
    .wbResult    (wb_result),
    .fwdVal      (ex_op_b)
  );

`ifdef OPERAND_STAGE_PERF_EN
  logic bubbleEvt;
  logic stallEvt;

  assign bubbleEvt = !flush && advance && hazard;
  assign stallEvt  = id_valid && !id_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_bubbles <= '0;
      perf_stalls  <= '0;
    end else begin
      if (bubbleEvt && perf_bubbles != '1) perf_bubbles <= perf_bubbles + 32'd1;
      if (stallEvt && perf_stalls != '1)   perf_stalls  <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_operand_stage.sv
// Self-checking bench for operand_stage: directed scenarios followed by
// random traffic, compared against a behavioural model of the stage.
module tb_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2, id_regwrite, id_memread;
  logic [63:0] id_imm, rf_rdata1, rf_rdata2;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_regwrite, wb_regwrite;
  logic [63:0] mem_result, wb_result;
  logic        ex_valid, ex_ready;
  logic [63:0] ex_op_a, ex_op_b, ex_imm;
  logic [4:0]  ex_rd;
  logic        ex_regwrite, ex_memread;
`ifdef OPERAND_STAGE_PERF_EN
  logic [31:0] perf_bubbles, perf_stalls;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model of the ID/EX contents.
  logic        mValid;
  logic [4:0]  mRs1, mRs2, mRd;
  logic        mRw, mMr;
  logic [63:0] mA, mB, mImm;
  int unsigned mBubbles, mStalls;

  always #5 clk = ~clk;

  operand_stage dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_regwrite  (id_regwrite),
    .id_memread   (id_memread),
    .id_imm       (id_imm),
    .rf_rdata1    (rf_rdata1),
    .rf_rdata2    (rf_rdata2),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .mem_result   (mem_result),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .wb_result    (wb_result),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_op_a      (ex_op_a),
    .ex_op_b      (ex_op_b),
    .ex_imm       (ex_imm),
    .ex_rd        (ex_rd),
    .ex_regwrite  (ex_regwrite),
    .ex_memread   (ex_memread)
`ifdef OPERAND_STAGE_PERF_EN
    ,
    .perf_bubbles (perf_bubbles),
    .perf_stalls  (perf_stalls)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Value the ALU should see for a source: zero register, then the youngest
  // in-flight writer, then the captured value.
  function automatic logic [63:0] expFwd(input logic [4:0] rs, input logic [63:0] v);
    if (rs == 5'd31) return 64'd0;
    if (mem_regwrite && mem_rd == rs) return mem_result;
    if (wb_regwrite && wb_rd == rs) return wb_result;
    return v;
  endfunction

  function automatic logic [63:0] expCapture(input logic [4:0] rs, input logic [63:0] rf);
    if (wb_regwrite && wb_rd == rs && rs != 5'd31) return wb_result;
    return rf;
  endfunction

  function automatic logic modelHazard();
    return mValid && mMr && mRd != 5'd31 &&
           ((id_use_rs1 && id_rs1 == mRd) || (id_use_rs2 && id_rs2 == mRd));
  endfunction

  function automatic logic modelReady();
    return (!mValid || ex_ready) && !modelHazard() && !flush;
  endfunction

  task automatic modelClear();
    mValid = 0; mRs1 = 0; mRs2 = 0; mRd = 0; mRw = 0; mMr = 0;
    mA = 0; mB = 0; mImm = 0; mBubbles = 0; mStalls = 0;
  endtask

  task automatic checkOutputs();
    check("id_ready",    id_ready,    modelReady());
    check("ex_valid",    ex_valid,    mValid);
    check("ex_op_a",     ex_op_a,     expFwd(mRs1, mA));
    check("ex_op_b",     ex_op_b,     expFwd(mRs2, mB));
    check("ex_imm",      ex_imm,      mImm);
    check("ex_rd",       ex_rd,       mRd);
    check("ex_regwrite", ex_regwrite, mRw);
    check("ex_memread",  ex_memread,  mMr);
`ifdef OPERAND_STAGE_PERF_EN
    check("perf_bubbles", perf_bubbles, mBubbles);
    check("perf_stalls",  perf_stalls,  mStalls);
`endif
  endtask

  // Called at a negedge with inputs set: check, advance the model, clock.
  task automatic step();
    logic adv, hz, rdy;
    #1;
    checkOutputs();
    adv = !mValid || ex_ready;
    hz  = modelHazard();
    rdy = modelReady();
    if (id_valid && !rdy) mStalls++;
    if (flush) begin
      mValid = 0;
    end else if (adv && hz) begin
      mValid = 0; mRw = 0; mMr = 0; mBubbles++;
    end else if (id_valid && rdy) begin
      mValid = 1;
      mA = expCapture(id_rs1, rf_rdata1);
      mB = expCapture(id_rs2, rf_rdata2);
      mRs1 = id_rs1; mRs2 = id_rs2; mRd = id_rd;
      mRw = id_regwrite; mMr = id_memread; mImm = id_imm;
    end else if (adv) begin
      mValid = 0;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle();
    flush = 0; id_valid = 0; ex_ready = 1;
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_rd = 0;
    id_regwrite = 0; id_memread = 0; id_imm = 0;
    rf_rdata1 = 0; rf_rdata2 = 0;
    mem_rd = 0; mem_regwrite = 0; mem_result = 0;
    wb_rd = 0; wb_regwrite = 0; wb_result = 0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic ld, input logic [63:0] a, input logic [63:0] b);
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = 1; id_use_rs2 = 1;
    id_rd = rd; id_regwrite = 1; id_memread = ld; id_imm = 64'h7;
    rf_rdata1 = a; rf_rdata2 = b;
  endtask

  function automatic logic [4:0] pickReg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 5'd31 : 5'(r);
  endfunction

  initial begin
    idle();
    reset = 1;
    modelClear();
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_ex_valid", ex_valid, 0);
    check("rst_ex_op_a",  ex_op_a,  0);
    check("rst_ex_op_b",  ex_op_b,  0);
    check("rst_ex_rd",    ex_rd,    0);
    reset = 0;
    @(negedge clk);

    // Plain pass.
    issue(5'd1, 5'd2, 5'd4, 0, 64'h10, 64'h20);
    step();
    idle();
    #1;
    check("pass_valid", ex_valid, 1);
    check("pass_op_a",  ex_op_a,  64'h10);
    check("pass_op_b",  ex_op_b,  64'h20);
    step();

    // EX/MEM beats MEM/WB.
    issue(5'd3, 5'd2, 5'd4, 0, 64'h33, 64'h44);
    step();
    idle();
    mem_rd = 3; mem_regwrite = 1; mem_result = 64'hAA;
    wb_rd = 3;  wb_regwrite = 1;  wb_result = 64'hBB;
    #1;
    check("memprio_op_a", ex_op_a, 64'hAA);
    step();
    idle();

    // Load-use on rs2.
    issue(5'd1, 5'd2, 5'd5, 1, 64'h1, 64'h2);
    step();
    issue(5'd0, 5'd5, 5'd6, 0, 64'h3, 64'h4);
    id_use_rs1 = 0;
    #1;
    check("lu_stall_ready", id_ready, 0);
    step();
    #1;
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_bubble_ready", id_ready, 1);
    step();
    idle();
    #1;
    check("lu_cap_valid", ex_valid, 1);
    check("lu_cap_rd",    ex_rd,    6);
    step();

    // Zero register.
    issue(5'd31, 5'd1, 5'd7, 0, 64'h99, 64'h5);
    step();
    idle();
    mem_rd = 31; mem_regwrite = 1; mem_result = 64'hFF;
    #1;
    check("zero_op_a", ex_op_a, 0);
    step();
    idle();
    issue(5'd1, 5'd2, 5'd31, 1, 64'h1, 64'h2);
    step();
    issue(5'd31, 5'd31, 5'd8, 0, 64'h0, 64'h0);
    #1;
    check("zero_ld_ready", id_ready, 1);
    step();
    idle();

    // Backpressure then flush.
    issue(5'd1, 5'd2, 5'd9, 0, 64'h11, 64'h22);
    step();
    issue(5'd3, 5'd4, 5'd10, 0, 64'h55, 64'h66);
    ex_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready", id_ready, 0);
      check("bp_op_a",  ex_op_a,  64'h11);
      check("bp_valid", ex_valid, 1);
      step();
    end
    flush = 1;
    step();
    flush = 0;
    id_valid = 0;
    #1;
    check("flush_valid", ex_valid, 0);
    ex_ready = 1;
    step();

    // Async reset between edges after a capture.
    issue(5'd1, 5'd2, 5'd4, 0, 64'h12, 64'h34);
    step();
    idle();
    #1;
    reset = 1;
    #1;
    check("areset_valid", ex_valid, 0);
    check("areset_op_a",  ex_op_a,  0);
`ifdef OPERAND_STAGE_PERF_EN
    check("areset_bubbles", perf_bubbles, 0);
    check("areset_stalls",  perf_stalls,  0);
`endif
    #1;
    reset = 0;
    modelClear();
    @(negedge clk);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      id_valid     = ($urandom_range(0, 3) != 0);
      id_rs1       = pickReg();
      id_rs2       = pickReg();
      id_use_rs1   = $urandom_range(0, 1);
      id_use_rs2   = $urandom_range(0, 1);
      id_rd        = pickReg();
      id_regwrite  = $urandom_range(0, 1);
      id_memread   = ($urandom_range(0, 2) == 0);
      id_imm       = {$urandom, $urandom};
      rf_rdata1    = {$urandom, $urandom};
      rf_rdata2    = {$urandom, $urandom};
      mem_rd       = pickReg();
      mem_regwrite = $urandom_range(0, 1);
      mem_result   = {$urandom, $urandom};
      wb_rd        = pickReg();
      wb_regwrite  = $urandom_range(0, 1);
      wb_result    = {$urandom, $urandom};
      ex_ready     = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
